// File: rtl/memory_bus_slave.sv
// rtl/memory_bus_slave.sv - BRAM-backed memory bus slave with in-order tagged read responses
// Optional MEMORY_SLAVE_WRITE_ACK_EN: writes also return an in-order {ID, data} response.
module memory_bus_slave #(
    parameter int                         DATA_WIDTH      = 24,
    parameter int                         ADDRESS_WIDTH   = 32,
    parameter int                         MASTER_ID_WIDTH = 8,
    parameter logic [ADDRESS_WIDTH-1:0]   BASE_ADDRESS    = '0,
    parameter int                         DEPTH_LOG2      = 10,
    parameter int                         RESP_DEPTH      = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [MASTER_ID_WIDTH-1:0] msID,
    input  logic [ADDRESS_WIDTH-1:0]   msAddress,
    input  logic [DATA_WIDTH-1:0]      msData,
    input  logic                       msWrite,
    input  logic                       msValid,
    output logic                       msTaken,
    output logic [MASTER_ID_WIDTH-1:0] smID,
    output logic [DATA_WIDTH-1:0]      smData,
    output logic                       smValid,
    input  logic                       smTaken
);

    localparam int PTR_W = $clog2(RESP_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0]      r_mem [2**DEPTH_LOG2];
    logic [DATA_WIDTH-1:0]      r_bram_q;
    logic [MASTER_ID_WIDTH-1:0] r_fifo_id   [RESP_DEPTH];
    logic [DATA_WIDTH-1:0]      r_fifo_data [RESP_DEPTH];

    logic                       r_s0_valid;
    logic [DEPTH_LOG2-1:0]      r_s0_index;
    logic [MASTER_ID_WIDTH-1:0] r_s0_id;
    logic                       r_s1_valid;
    logic [MASTER_ID_WIDTH-1:0] r_s1_id;

    logic [PTR_W-1:0]           r_wr_ptr;
    logic [PTR_W-1:0]           r_rd_ptr;
    logic [CNT_W-1:0]           r_count;
    logic [CNT_W-1:0]           r_credits;

    logic [ADDRESS_WIDTH-1:0]   w_offset;
    logic [DEPTH_LOG2-1:0]      w_index;
    logic                       w_in_range;
    logic                       w_credit_ok;
    logic                       w_take;
    logic                       w_write;
    logic                       w_push_req;
    logic                       w_pop;

    assign w_offset    = msAddress - BASE_ADDRESS;
    assign w_index     = w_offset[DEPTH_LOG2-1:0];
    assign w_in_range  = (msAddress >= BASE_ADDRESS) && ((w_offset >> DEPTH_LOG2) == '0);
    assign w_credit_ok = r_credits < CNT_W'(RESP_DEPTH);

`ifdef MEMORY_SLAVE_WRITE_ACK_EN
    // Write acks ride the read pipeline: the BRAM read one edge after the write sees the new word.
    assign w_take     = reset && msValid && w_in_range && w_credit_ok;
    assign w_push_req = w_take;
`else
    assign w_take     = reset && msValid && w_in_range && (msWrite || w_credit_ok);
    assign w_push_req = w_take && !msWrite;
`endif

    assign w_write = w_take && msWrite;
    assign w_pop   = smTaken && (r_count != '0);
    assign msTaken = w_take;

    assign smValid = (r_count != '0);
    assign smID    = smValid ? r_fifo_id[r_rd_ptr]   : '0;
    assign smData  = smValid ? r_fifo_data[r_rd_ptr] : '0;

    always_ff @(posedge clock) begin
        if (w_write) begin
            r_mem[w_index] <= msData;
        end
        if (r_s0_valid) begin
            r_bram_q <= r_mem[r_s0_index];
        end
        if (r_s1_valid) begin
            r_fifo_id[r_wr_ptr]   <= r_s1_id;
            r_fifo_data[r_wr_ptr] <= r_bram_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s0_valid <= 1'b0;
            r_s0_index <= '0;
            r_s0_id    <= '0;
            r_s1_valid <= 1'b0;
            r_s1_id    <= '0;
        end else begin
            r_s0_valid <= w_push_req;
            if (w_push_req) begin
                r_s0_index <= w_index;
                r_s0_id    <= msID;
            end
            r_s1_valid <= r_s0_valid;
            r_s1_id    <= r_s0_id;
        end
    end

    // Credits cover the FIFO plus both pipeline stages, so a push can never overflow the FIFO.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_credits <= '0;
        end else begin
            if (r_s1_valid) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({r_s1_valid, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            case ({w_push_req, w_pop})
                2'b10:   r_credits <= r_credits + 1'b1;
                2'b01:   r_credits <= r_credits - 1'b1;
                default: r_credits <= r_credits;
            endcase
        end
    end

endmodule
